recv_arp_pkt: RTL and testbench

RECV_ARP_PKT -- requirements
Module: recv_arp_pkt

---
 rtl/recv_arp_pkt_pkg.sv | 48 ++++
 rtl/recv_arp_pkt.sv | 187 ++++++++++++++++++
 tb/tb_recv_arp_pkt.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/recv_arp_pkt_pkg.sv
// Shared ARP/Ethernet constants, field record and helpers for the ARP receive/send blocks.
package recv_arp_pkt_pkg;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

    // Beat positions within a frame, counted from the sop beat (index 0).
    localparam logic [3:0] BEAT_DST_LO   = 4'd1;
    localparam logic [3:0] BEAT_SRC_HI   = 4'd2;
    localparam logic [3:0] BEAT_SRC_TYPE = 4'd3;
    localparam logic [3:0] BEAT_HTYPE    = 4'd4;
    localparam logic [3:0] BEAT_LEN_OP   = 4'd5;
    localparam logic [3:0] BEAT_SHA_HI   = 4'd6;
    localparam logic [3:0] BEAT_SHA_SPA  = 4'd7;
    localparam logic [3:0] BEAT_SPA_THA  = 4'd8;
    localparam logic [3:0] BEAT_THA_LO   = 4'd9;
    localparam logic [3:0] BEAT_TPA      = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAD,
        S_DROP
    } rx_state_e;

    typedef struct packed {
        logic [15:0] opcode;
        logic [47:0] src_mac;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_fields_t;

    // 16-bit counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/recv_arp_pkt.sv
// ARP receive parser: walks a 32-bit beat stream, validates the ARP header and
// publishes the fields of each accepted packet with a one-cycle valid pulse.
//
// state  | meaning
// S_IDLE | waiting for a sop beat
// S_HDR  | capturing/validating header beats 1..10
// S_PAD  | header complete, counting padding beats until eop
// S_DROP | frame rejected, discarding beats until eop
module recv_arp_pkt
    import recv_arp_pkt_pkg::*;
#(
    parameter int MAX_WORDS   = 16,
    parameter int CHK_DST_MAC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_local_mac,
    input  logic [31:0] i_local_ip,
    input  logic        i_eth_sop,
    input  logic        i_eth_eop,
    input  logic        i_eth_vld,
    input  logic [31:0] i_eth_data,
    output logic        o_eth_rdy,
    output logic        o_arp_vld,
    output logic [15:0] o_arp_opcode,
    output logic [47:0] o_arp_src_mac,
    output logic [47:0] o_arp_sha,
    output logic [31:0] o_arp_spa,
    output logic [47:0] o_arp_tha,
    output logic [31:0] o_arp_tpa,
    output logic [15:0] o_rx_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(MAX_WORDS - 1);

    rx_state_e   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] dst_hi_q, dst_hi_d;
    arp_fields_t wk_q, wk_d;
    arp_fields_t out_q;
    logic        vld_q, rdy_q;
    logic [15:0] rx_q, drop_q;
    logic        beat, beat_ok, accept;
    logic [1:0]  drop_inc;

    assign beat = i_eth_vld & rdy_q;

    // Next-state, beat capture and per-beat header checks.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dst_hi_d = dst_hi_q;
        wk_d     = wk_q;
        accept   = 1'b0;
        drop_inc = 2'd0;
        beat_ok  = 1'b1;
        if (beat) begin
            if (i_eth_sop) begin
                // A sop always restarts; an in-flight frame not yet counted is dropped.
                if (state_q == S_HDR || state_q == S_PAD) drop_inc = drop_inc + 2'd1;
                dst_hi_d = i_eth_data[15:0];
                idx_d    = BEAT_DST_LO;
                if (i_eth_data[31:16] != 16'h0000 || i_eth_eop) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = i_eth_eop ? S_IDLE : S_DROP;
                end else begin
                    state_d = S_HDR;
                end
            end else begin
                case (state_q)
                    S_HDR: begin
                        case (idx_q)
                            BEAT_DST_LO: begin
                                if (CHK_DST_MAC != 0)
                                    beat_ok = ({dst_hi_q, i_eth_data} == MAC_BROADCAST) ||
                                              ({dst_hi_q, i_eth_data} == i_local_mac);
                            end
                            BEAT_SRC_HI: wk_d.src_mac[47:16] = i_eth_data;
                            BEAT_SRC_TYPE: begin
                                wk_d.src_mac[15:0] = i_eth_data[31:16];
                                beat_ok = (i_eth_data[15:0] == ETH_TYPE_ARP);
                            end
                            BEAT_HTYPE: begin
                                beat_ok = (i_eth_data[31:16] == ARP_HTYPE_ETH) &&
                                          (i_eth_data[15:0] == ARP_PTYPE_IPV4);
                            end
                            BEAT_LEN_OP: begin
                                wk_d.opcode = i_eth_data[15:0];
                                beat_ok = (i_eth_data[31:24] == ARP_HLEN) &&
                                          (i_eth_data[23:16] == ARP_PLEN) &&
                                          ((i_eth_data[15:0] == ARP_OP_REQUEST) ||
                                           (i_eth_data[15:0] == ARP_OP_REPLY));
                            end
                            BEAT_SHA_HI: wk_d.sha[47:16] = i_eth_data;
                            BEAT_SHA_SPA: begin
                                wk_d.sha[15:0]  = i_eth_data[31:16];
                                wk_d.spa[31:16] = i_eth_data[15:0];
                            end
                            BEAT_SPA_THA: begin
                                wk_d.spa[15:0]  = i_eth_data[31:16];
                                wk_d.tha[47:32] = i_eth_data[15:0];
                            end
                            BEAT_THA_LO: wk_d.tha[31:0] = i_eth_data;
                            BEAT_TPA: begin
                                wk_d.tpa = i_eth_data;
                                beat_ok  = (i_eth_data == i_local_ip);
                            end
                            default: ;
                        endcase
                        idx_d = idx_q + 4'd1;
                        if (!beat_ok) begin
                            drop_inc = drop_inc + 2'd1;
                            state_d  = i_eth_eop ? S_IDLE : S_DROP;
                        end else if (idx_q == BEAT_TPA) begin
                            accept  = i_eth_eop;
                            state_d = i_eth_eop ? S_IDLE : S_PAD;
                        end else if (i_eth_eop) begin
                            drop_inc = drop_inc + 2'd1;
                            state_d  = S_IDLE;
                        end
                    end
                    S_PAD: begin
                        idx_d = idx_q + 4'd1;
                        if (i_eth_eop) begin
                            accept  = 1'b1;
                            state_d = S_IDLE;
                        end else if (idx_q == LAST_IDX) begin
                            drop_inc = drop_inc + 2'd1;
                            state_d  = S_DROP;
                        end
                    end
                    S_DROP: begin
                        if (i_eth_eop) state_d = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM state, beat index and working-register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            dst_hi_q <= 16'h0000;
            wk_q     <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dst_hi_q <= dst_hi_d;
            wk_q     <= wk_d;
            rdy_q    <= 1'b1;
        end
    end

    // Published fields, valid pulse and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            vld_q  <= 1'b0;
            rx_q   <= 16'h0000;
            drop_q <= 16'h0000;
        end else begin
            vld_q  <= accept;
            if (accept) begin
                out_q <= wk_d;
                rx_q  <= sat_add(rx_q, 2'd1);
            end
            drop_q <= sat_add(drop_q, drop_inc);
        end
    end

    assign o_eth_rdy     = rdy_q;
    assign o_arp_vld     = vld_q;
    assign o_arp_opcode  = out_q.opcode;
    assign o_arp_src_mac = out_q.src_mac;
    assign o_arp_sha     = out_q.sha;
    assign o_arp_spa     = out_q.spa;
    assign o_arp_tha     = out_q.tha;
    assign o_arp_tpa     = out_q.tpa;
    assign o_rx_cnt      = rx_q;
    assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_recv_arp_pkt.sv
// Self-checking bench for recv_arp_pkt: directed frames, frame-level reference model,
// per-cycle output comparison plus literal spot checks.
module tb_recv_arp_pkt;

    localparam int MAX_WORDS = 16;

    typedef struct {
        logic [15:0] opcode;
        logic [47:0] src;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_t;

    typedef struct {
        int   cyc;
        arp_t f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] lmac;
    logic [31:0] lip;
    logic        sop, eop, vld;
    logic [31:0] data;
    logic        rdy, arp_vld;
    logic [15:0] opcode, rx_cnt, drop_cnt;
    logic [47:0] src_mac, sha, tha;
    logic [31:0] spa, tpa;

    recv_arp_pkt #(.MAX_WORDS(MAX_WORDS), .CHK_DST_MAC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_local_mac(lmac), .i_local_ip(lip),
        .i_eth_sop(sop), .i_eth_eop(eop), .i_eth_vld(vld), .i_eth_data(data),
        .o_eth_rdy(rdy), .o_arp_vld(arp_vld), .o_arp_opcode(opcode),
        .o_arp_src_mac(src_mac), .o_arp_sha(sha), .o_arp_spa(spa),
        .o_arp_tha(tha), .o_arp_tpa(tpa),
        .o_rx_cnt(rx_cnt), .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] fb [0:31];
    exp_t        q[$];
    arp_t        mdl_out;
    logic [15:0] mdl_rx;
    logic [15:0] mdl_drop;
    bit          rdy_expect;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Frame-level reference: a frame is accepted only if it ends in eop, is 11..MAX_WORDS
    // beats long and every header field is valid; otherwise it costs exactly one drop.
    function automatic bit model(input int len, input bit has_eop, output arp_t f);
        logic [47:0] dst;
        bit ok;
        dst = {fb[0][15:0], fb[1]};
        f.src    = {fb[2], fb[3][31:16]};
        f.opcode = fb[5][15:0];
        f.sha    = {fb[6], fb[7][31:16]};
        f.spa    = {fb[7][15:0], fb[8][31:16]};
        f.tha    = {fb[8][15:0], fb[9]};
        f.tpa    = fb[10];
        ok = has_eop && len >= 11 && len <= MAX_WORDS;
        ok = ok && fb[0][31:16] == 16'h0000;
        ok = ok && (dst == 48'hFFFF_FFFF_FFFF || dst == lmac);
        ok = ok && fb[3][15:0] == 16'h0806 && fb[4] == 32'h0001_0800;
        ok = ok && fb[5][31:16] == 16'h0604 && (f.opcode == 16'd1 || f.opcode == 16'd2);
        ok = ok && f.tpa == lip;
        return ok;
    endfunction

    task automatic build(input logic [15:0] opc, input logic [47:0] dst, input logic [15:0] etype,
                         input logic [47:0] s_mac, input logic [31:0] s_ip,
                         input logic [47:0] t_mac, input logic [31:0] t_ip);
        for (int i = 0; i < 32; i++) fb[i] = 32'h0;
        fb[0]  = {16'h0000, dst[47:32]};
        fb[1]  = dst[31:0];
        fb[2]  = s_mac[47:16];
        fb[3]  = {s_mac[15:0], etype};
        fb[4]  = 32'h0001_0800;
        fb[5]  = {8'h06, 8'h04, opc};
        fb[6]  = s_mac[47:16];
        fb[7]  = {s_mac[15:0], s_ip[31:16]};
        fb[8]  = {s_ip[15:0], t_mac[47:32]};
        fb[9]  = t_mac[31:0];
        fb[10] = t_ip;
    endtask

    // Drives beats 0..len-1 of fb back-to-back; the model is updated as the last beat goes out.
    task automatic send(input int len, input bit with_eop, input bit count_drop);
        arp_t f;
        exp_t e;
        for (int i = 0; i < len; i++) begin
            vld  = 1'b1;
            sop  = (i == 0);
            eop  = with_eop && (i == len - 1);
            data = fb[i];
            if (i == len - 1) begin
                if (model(len, with_eop, f)) begin
                    e.cyc = cyc + 1;
                    e.f   = f;
                    q.push_back(e);
                end else if (count_drop) begin
                    mdl_drop = sat16(mdl_drop);
                end
            end
            @(posedge clk); #1;
        end
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_drop(input string nm, input logic [15:0] lit);
        chk(nm, drop_cnt, mdl_drop);
        chk({nm, "_lit"}, drop_cnt, lit);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit exp_v;
        exp_v = 1'b0;
        if (!rst_n) begin
            mdl_out = '{default: '0};
            mdl_rx  = 16'h0000;
            chk("rdy_in_reset", {63'd0, rdy}, 64'd0);
        end else begin
            if (rdy_expect) chk("rdy", {63'd0, rdy}, 64'd1);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_v   = 1'b1;
                mdl_out = q[0].f;
                mdl_rx  = sat16(mdl_rx);
                void'(q.pop_front());
            end
        end
        chk("arp_vld", {63'd0, arp_vld}, {63'd0, exp_v});
        chk("opcode", {48'd0, opcode}, {48'd0, mdl_out.opcode});
        chk("src_mac", {16'd0, src_mac}, {16'd0, mdl_out.src});
        chk("sha", {16'd0, sha}, {16'd0, mdl_out.sha});
        chk("spa", {32'd0, spa}, {32'd0, mdl_out.spa});
        chk("tha", {16'd0, tha}, {16'd0, mdl_out.tha});
        chk("tpa", {32'd0, tpa}, {32'd0, mdl_out.tpa});
        chk("rx_cnt", {48'd0, rx_cnt}, {48'd0, mdl_rx});
    end

    localparam logic [47:0] PEER_MAC  = 48'h0011_2233_4455;
    localparam logic [47:0] OTHER_MAC = 48'h0A0B_0C0D_0E0F;

    initial begin
        rst_n = 1'b0; vld = 1'b0; sop = 1'b0; eop = 1'b0; data = 32'h0;
        lmac = 48'h0200_0000_0001; lip = 32'hC0A8_0102;
        mdl_drop = 16'h0; rdy_expect = 1'b0;
        mdl_out = '{default: '0}; mdl_rx = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", {63'd0, rdy}, 64'd0);
        chk("reset_rx", {48'd0, rx_cnt}, 64'd0);
        chk("reset_drop", {48'd0, drop_cnt}, 64'd0);
        rst_n = 1'b1;
        idle(2);
        rdy_expect = 1'b1;

        // Broadcast request, 11 beats, eop on beat 10.
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0101, 48'h0, 32'hC0A8_0102);
        send(11, 1, 1);
        @(negedge clk);
        chk("req_vld_lit", {63'd0, arp_vld}, 64'd1);
        chk("req_opcode_lit", {48'd0, opcode}, 64'd1);
        chk("req_sha_lit", {16'd0, sha}, 64'h0000_0011_2233_4455);
        chk("req_spa_lit", {32'd0, spa}, 64'h0000_0000_C0A8_0101);
        chk("req_rx_lit", {48'd0, rx_cnt}, 64'd1);
        @(negedge clk);
        chk("req_vld_drop_lit", {63'd0, arp_vld}, 64'd0);
        idle(1);

        // Unicast reply to us, 12 beats with zero pad.
        build(16'd2, 48'h0200_0000_0001, 16'h0806, OTHER_MAC, 32'h0A00_0005, 48'h0200_0000_0001, 32'hC0A8_0102);
        send(12, 1, 1);
        idle(2);
        chk("rep_tha_lit", {16'd0, tha}, 64'h0000_0200_0000_0001);
        chk("rep_rx_lit", {48'd0, rx_cnt}, 64'd2);

        // Wrong ethertype: dropped, outputs held.
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0800, PEER_MAC, 32'hC0A8_0109, 48'h0, 32'hC0A8_0102);
        send(11, 1, 1);
        idle(2);
        chk_drop("type_drop", 16'd1);

        // eop on beat 7, then a good frame back-to-back.
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0107, 48'h0, 32'hC0A8_0102);
        send(8, 1, 1);
        build(16'd2, 48'hFFFF_FFFF_FFFF, 16'h0806, OTHER_MAC, 32'hC0A8_0133, 48'h1, 32'hC0A8_0102);
        send(11, 1, 1);
        idle(2);
        chk_drop("short_drop", 16'd2);

        // sop on beat 5 aborts; second frame accepted.
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0111, 48'h0, 32'hC0A8_0102);
        send(5, 0, 1);
        build(16'd1, 48'h0200_0000_0001, 16'h0806, PEER_MAC, 32'hC0A8_0122, 48'h0, 32'hC0A8_0102);
        send(13, 1, 1);
        idle(2);
        chk_drop("abort_drop", 16'd3);
        chk("abort_rx_lit", {48'd0, rx_cnt}, 64'd4);

        // 17 beats: no eop by beat 15 -> dropped.
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0144, 48'h0, 32'hC0A8_0102);
        send(17, 1, 1);
        idle(2);
        chk_drop("long_drop", 16'd4);

        // Exactly MAX_WORDS beats with non-zero padding -> accepted.
        build(16'd2, 48'hFFFF_FFFF_FFFF, 16'h0806, OTHER_MAC, 32'hC0A8_0155, 48'h5, 32'hC0A8_0102);
        for (int i = 11; i < 32; i++) fb[i] = 32'hA5A5_5A5A;
        send(16, 1, 1);
        idle(2);
        chk("max_rx_lit", {48'd0, rx_cnt}, 64'd5);

        // Foreign dst MAC, wrong tpa, bad opcode: all dropped.
        build(16'd1, OTHER_MAC, 16'h0806, PEER_MAC, 32'hC0A8_0166, 48'h0, 32'hC0A8_0102);
        send(11, 1, 1);
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0177, 48'h0, 32'hC0A8_0103);
        send(11, 1, 1);
        build(16'd3, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0188, 48'h0, 32'hC0A8_0102);
        send(11, 1, 1);
        idle(2);
        chk_drop("field_drop", 16'd7);

        // Reset mid-frame: everything cleared, stray non-sop beat ignored, next frame accepted.
        build(16'd1, 48'hFFFF_FFFF_FFFF, 16'h0806, PEER_MAC, 32'hC0A8_0199, 48'h0, 32'hC0A8_0102);
        send(6, 0, 0);
        rst_n = 1'b0; rdy_expect = 1'b0; mdl_drop = 16'h0; q.delete();
        @(negedge clk);
        chk("rst_rx_lit", {48'd0, rx_cnt}, 64'd0);
        chk("rst_drop_lit", {48'd0, drop_cnt}, 64'd0);
        chk("rst_tpa_lit", {32'd0, tpa}, 64'd0);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        rdy_expect = 1'b1;
        vld = 1'b1; data = 32'h0000_FFFF;
        @(posedge clk); #1;
        vld = 1'b0;
        build(16'd2, 48'h0200_0000_0001, 16'h0806, OTHER_MAC, 32'hC0A8_01AA, 48'h0200_0000_0001, 32'hC0A8_0102);
        send(11, 1, 1);
        idle(3);
        chk("post_rst_rx_lit", {48'd0, rx_cnt}, 64'd1);
        chk_drop("post_rst_drop", 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
